axi_read_arb2: RTL

- Two-requester arbiter/scheduler for the shared AXI4 read master channel (AR + R) of the stream pipeline.
- Accepts burst read commands from two clients and issues them on AR with round-robin fairness.
- Tags each command with the client index in ARID, and routes R beats back to the owner by RID.
- Limits outstanding bursts per client.

---
 rtl/axi_read_arb2.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_arb2.sv
// rtl/axi_read_arb2.sv - two-client AXI4 read arbiter with RID routing; `AXI_RD_ARB_STRICT_PRIO_EN selects fixed priority
module axi_read_arb2 #(
    parameter int C_AXI_ADDR_WIDTH      = 32,
    parameter int C_AXI_DATA_WIDTH      = 128,
    parameter int C_AXI_THREAD_ID_WIDTH = 1,
    parameter int MAX_OUTSTANDING       = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    // client 0 command and read data
    input  logic                             REQ0_VALID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]      REQ0_ADDR,
    input  logic [7:0]                       REQ0_LEN,
    output logic                             REQ0_READY,
    output logic [C_AXI_DATA_WIDTH-1:0]      RD0_DATA,
    output logic                             RD0_LAST,
    output logic                             RD0_VALID,
    input  logic                             RD0_READY,
    // client 1 command and read data
    input  logic                             REQ1_VALID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]      REQ1_ADDR,
    input  logic [7:0]                       REQ1_LEN,
    output logic                             REQ1_READY,
    output logic [C_AXI_DATA_WIDTH-1:0]      RD1_DATA,
    output logic                             RD1_LAST,
    output logic                             RD1_VALID,
    input  logic                             RD1_READY,
    output logic                             ERR_FLAG,
    // shared AXI4 read address channel
    output logic [C_AXI_THREAD_ID_WIDTH-1:0] AXI_ARID,
    output logic [C_AXI_ADDR_WIDTH-1:0]      AXI_ARADDR,
    output logic [7:0]                       AXI_ARLEN,
    output logic [2:0]                       AXI_ARSIZE,
    output logic [1:0]                       AXI_ARBURST,
    output logic                             AXI_ARLOCK,
    output logic [3:0]                       AXI_ARCACHE,
    output logic [2:0]                       AXI_ARPROT,
    output logic [3:0]                       AXI_ARQOS,
    output logic                             AXI_ARUSER,
    output logic                             AXI_ARVALID,
    input  logic                             AXI_ARREADY,
    // shared AXI4 read data channel
    input  logic [C_AXI_THREAD_ID_WIDTH-1:0] AXI_RID,
    input  logic [C_AXI_DATA_WIDTH-1:0]      AXI_RDATA,
    input  logic [1:0]                       AXI_RRESP,
    input  logic                             AXI_RLAST,
    input  logic                             AXI_RVALID,
    output logic                             AXI_RREADY
);

    localparam logic [2:0] AR_SIZE = 3'($clog2(C_AXI_DATA_WIDTH / 8));
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic                          arvalid_q, arvalid_d;
    logic                          arid_q, arid_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]                    arlen_q, arlen_d;
    logic [3:0]                    cnt0_q, cnt0_d;
    logic [3:0]                    cnt1_q, cnt1_d;
    logic                          err_q, err_d;
`ifndef AXI_RD_ARB_STRICT_PRIO_EN
    logic                          rr_q, rr_d;
`endif

    logic elig0, elig1;
    logic grant0, grant1;
    logic in_idle;
    logic ar_hs;
    logic r_hs;
    logic r_sel;
    logic unused_rid;

    // Only RID[0] carries the client index; upper ID bits are deliberately dropped.
    assign unused_rid = ^AXI_RID;
    assign r_sel      = AXI_RID[0];

    // Counter update: a same-cycle issue and completion for one client cancel out.
    function automatic logic [3:0] next_cnt(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'd0)) begin
            res = cnt - 4'd1;
        end
        return res;
    endfunction

    // Eligibility and grant selection; the full client is skipped, the other still served.
    always_comb begin
        elig0 = REQ0_VALID && (cnt0_q < MAX_CNT);
        elig1 = REQ1_VALID && (cnt1_q < MAX_CNT);
`ifdef AXI_RD_ARB_STRICT_PRIO_EN
        grant0 = elig0;
        grant1 = elig1 && !elig0;
`else
        grant0 = elig0 && (!elig1 || !rr_q);
        grant1 = elig1 && (!elig0 || rr_q);
`endif
        in_idle    = (state_q == S_IDLE) && !RST;
        REQ0_READY = in_idle && grant0;
        REQ1_READY = in_idle && grant1;
    end

    // Unbuffered R routing by RID[0]; data and last fan out to both clients.
    always_comb begin
        RD0_DATA   = AXI_RDATA;
        RD1_DATA   = AXI_RDATA;
        RD0_LAST   = AXI_RLAST;
        RD1_LAST   = AXI_RLAST;
        RD0_VALID  = AXI_RVALID && !r_sel;
        RD1_VALID  = AXI_RVALID && r_sel;
        AXI_RREADY = AXI_RVALID && (r_sel ? RD1_READY : RD0_READY);
    end

    // Next-state logic: command FSM, outstanding counters, sticky error.
    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
`ifndef AXI_RD_ARB_STRICT_PRIO_EN
        rr_d      = rr_q;
`endif
        ar_hs = arvalid_q && AXI_ARREADY;
        r_hs  = AXI_RVALID && AXI_RREADY;

        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    state_d   = S_ISSUE;
                    arvalid_d = 1'b1;
                    arid_d    = grant1;
                    araddr_d  = grant1 ? REQ1_ADDR : REQ0_ADDR;
                    arlen_d   = grant1 ? REQ1_LEN : REQ0_LEN;
                end
            end
            S_ISSUE: begin
                if (ar_hs) begin
                    state_d   = S_IDLE;
                    arvalid_d = 1'b0;
`ifndef AXI_RD_ARB_STRICT_PRIO_EN
                    rr_d      = ~arid_q;
`endif
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
            end
        endcase

        cnt0_d = next_cnt(cnt0_q, ar_hs && !arid_q, r_hs && AXI_RLAST && !r_sel);
        cnt1_d = next_cnt(cnt1_q, ar_hs && arid_q, r_hs && AXI_RLAST && r_sel);
        err_d  = err_q || (r_hs && (AXI_RRESP != 2'b00));
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            arvalid_q <= 1'b0;
            arid_q    <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            err_q     <= 1'b0;
`ifndef AXI_RD_ARB_STRICT_PRIO_EN
            rr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            err_q     <= err_d;
`ifndef AXI_RD_ARB_STRICT_PRIO_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign AXI_ARVALID = arvalid_q;
    assign AXI_ARID    = C_AXI_THREAD_ID_WIDTH'(arid_q);
    assign AXI_ARADDR  = araddr_q;
    assign AXI_ARLEN   = arlen_q;
    assign AXI_ARSIZE  = AR_SIZE;
    assign AXI_ARBURST = 2'b01;
    assign AXI_ARLOCK  = 1'b0;
    assign AXI_ARCACHE = 4'b0011;
    assign AXI_ARPROT  = 3'b000;
    assign AXI_ARQOS   = 4'b0000;
    assign AXI_ARUSER  = 1'b0;
    assign ERR_FLAG    = err_q;

endmodule
